// File: rtl/lcd_bus_responder.sv
// lcd_bus_responder
// HD44780-style responder for the LCD side of the lcd_data/lcd_rs/lcd_rw/lcd_en bus.
// It decodes instruction and data writes, keeps shadow DDRAM (128 B, with a valid vector)
// and CGRAM (64 B), and answers busy-flag/address and data reads. A separate registered
// mirror port lets a bench or debug path inspect either memory.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   lcd_data/rs/rw/en         bus inputs from the master
//   lcd_data_out, lcd_data_oe read return value and its valid strobe
//   mir_sel, mir_addr         mirror select (0 DDRAM, 1 CGRAM) and address
//   mir_data                  mirror read data, one cycle after mir_sel/mir_addr
//   busy, ac                  busy flag and address counter
//   disp_on, cursor_on, blink_on, entry_inc, func_bits   control state
//   drop_flag                 sticky; a write arrived while busy
//
// Optional feature macro: LCD_RESP_TRACE_EN adds trace_valid/trace_word, a one-cycle
// pulse with {rs,rw,data} on every accepted write or read fall.
module lcd_bus_responder #(
    parameter int unsigned CLEAR_CYCLES = 0,
    parameter int unsigned BUSY_CYCLES  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] lcd_data,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    output logic [7:0] lcd_data_out,
    output logic       lcd_data_oe,
    input  logic       mir_sel,
    input  logic [6:0] mir_addr,
    output logic [7:0] mir_data,
    output logic       busy,
    output logic [6:0] ac,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic [2:0] func_bits,
`ifdef LCD_RESP_TRACE_EN
    output logic       trace_valid,
    output logic [9:0] trace_word,
`endif
    output logic       drop_flag
);

    localparam logic [31:0] BusyLoad  = 32'(BUSY_CYCLES);
    localparam logic [31:0] ClearLoad = 32'(CLEAR_CYCLES);

    logic         en_q, rs_q, rw_q;
    logic [7:0]   data_q;
    logic [6:0]   ac_q, ac_d;
    logic         tgt_cg_q, tgt_cg_d;
    logic         disp_q, disp_d, cursor_q, cursor_d, blink_q, blink_d, entry_q, entry_d;
    logic [2:0]   func_q, func_d;
    logic         drop_q, drop_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [127:0] ddv_q;
    logic         ddv_clr;
    logic [7:0]   dout_q, mir_q;
    logic         oe_q;
    logic [7:0]   ddram [128];
    logic [7:0]   cgram [64];

    logic       rise, fall, busy_int, wr_fire, cmd_wr, data_wr, rd_rise, rd_fall;
    logic [7:0] rd_mem, rd_val, mir_val;

    // CGRAM addresses stay within 6 bits; DDRAM uses the full 7-bit wrap.
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic cg,
                                           input logic inc);
        logic [6:0] n;
        n = inc ? a + 7'd1 : a - 7'd1;
        if (cg) n[6] = 1'b0;
        return n;
    endfunction

    assign rise     = ~en_q & lcd_en;
    assign fall     = en_q & ~lcd_en;
    assign busy_int = (cnt_q != '0);
    assign wr_fire  = fall & ~rw_q & ~busy_int;
    assign cmd_wr   = wr_fire & ~rs_q;
    assign data_wr  = wr_fire & rs_q;
    // Read direction comes from the live bus at the rise; registered copies lag a cycle.
    assign rd_rise  = rise & lcd_rw;
    assign rd_fall  = fall & rw_q;

    assign rd_mem  = tgt_cg_q ? cgram[ac_q[5:0]] : (ddv_q[ac_q] ? ddram[ac_q] : 8'h20);
    assign rd_val  = lcd_rs ? rd_mem : {busy_int, ac_q};
    assign mir_val = mir_sel ? cgram[mir_addr[5:0]]
                             : (ddv_q[mir_addr] ? ddram[mir_addr] : 8'h20);

    always_comb begin
        ac_d     = ac_q;
        tgt_cg_d = tgt_cg_q;
        disp_d   = disp_q;
        cursor_d = cursor_q;
        blink_d  = blink_q;
        entry_d  = entry_q;
        func_d   = func_q;
        ddv_clr  = 1'b0;
        drop_d   = drop_q;
        cnt_d    = busy_int ? cnt_q - 32'd1 : '0;
        if (cmd_wr) begin
            cnt_d = BusyLoad;
            // Instruction is identified by its highest set bit.
            unique casez (data_q)
                8'b1???????: begin ac_d = data_q[6:0]; tgt_cg_d = 1'b0; end
                8'b01??????: begin ac_d = {1'b0, data_q[5:0]}; tgt_cg_d = 1'b1; end
                8'b001?????: func_d = data_q[4:2];
                8'b0001????: if (!data_q[3]) ac_d = ac_step(ac_q, tgt_cg_q, data_q[2]);
                8'b00001???: begin
                    disp_d   = data_q[2];
                    cursor_d = data_q[1];
                    blink_d  = data_q[0];
                end
                8'b000001??: entry_d = data_q[1];
                8'b0000001?: begin
                    ac_d     = '0;
                    tgt_cg_d = 1'b0;
                    cnt_d    = ClearLoad;
                end
                8'b00000001: begin
                    ac_d     = '0;
                    tgt_cg_d = 1'b0;
                    entry_d  = 1'b1;
                    ddv_clr  = 1'b1;
                    cnt_d    = ClearLoad;
                end
                default: ;
            endcase
        end else if (data_wr) begin
            ac_d  = ac_step(ac_q, tgt_cg_q, entry_q);
            cnt_d = BusyLoad;
        end else if (rd_fall && rs_q) begin
            ac_d = ac_step(ac_q, tgt_cg_q, entry_q);
        end
        if (fall && !rw_q && busy_int) drop_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q     <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= '0;
            ac_q     <= '0;
            tgt_cg_q <= 1'b0;
            disp_q   <= 1'b0;
            cursor_q <= 1'b0;
            blink_q  <= 1'b0;
            entry_q  <= 1'b1;
            func_q   <= 3'b000;
            drop_q   <= 1'b0;
            cnt_q    <= '0;
            ddv_q    <= '0;
            dout_q   <= '0;
            oe_q     <= 1'b0;
            mir_q    <= '0;
        end else begin
            en_q     <= lcd_en;
            rs_q     <= lcd_rs;
            rw_q     <= lcd_rw;
            data_q   <= lcd_data;
            ac_q     <= ac_d;
            tgt_cg_q <= tgt_cg_d;
            disp_q   <= disp_d;
            cursor_q <= cursor_d;
            blink_q  <= blink_d;
            entry_q  <= entry_d;
            func_q   <= func_d;
            drop_q   <= drop_d;
            cnt_q    <= cnt_d;
            if (ddv_clr) begin
                ddv_q <= '0;
            end else if (data_wr && !tgt_cg_q) begin
                ddv_q[ac_q] <= 1'b1;
            end
            if (rd_rise) begin
                dout_q <= rd_val;
                oe_q   <= 1'b1;
            end else if (fall) begin
                oe_q <= 1'b0;
            end
            mir_q <= mir_val;
        end
    end

    // Memory contents carry no reset; DDRAM validity is tracked by ddv_q.
    always_ff @(posedge clk) begin
        if (data_wr) begin
            if (tgt_cg_q) cgram[ac_q[5:0]] <= data_q;
            else          ddram[ac_q]      <= data_q;
        end
    end

`ifdef LCD_RESP_TRACE_EN
    logic       trace_valid_q;
    logic [9:0] trace_word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid_q <= 1'b0;
            trace_word_q  <= '0;
        end else begin
            trace_valid_q <= fall & (rw_q | ~busy_int);
            if (fall) trace_word_q <= {rs_q, rw_q, data_q};
        end
    end

    assign trace_valid = trace_valid_q;
    assign trace_word  = trace_word_q;
`endif

    assign lcd_data_out = dout_q;
    assign lcd_data_oe  = oe_q;
    assign mir_data     = mir_q;
    assign busy         = busy_int;
    assign ac           = ac_q;
    assign disp_on      = disp_q;
    assign cursor_on    = cursor_q;
    assign blink_on     = blink_q;
    assign entry_inc    = entry_q;
    assign func_bits    = func_q;
    assign drop_flag    = drop_q;

endmodule

// File: tb/tb_lcd_bus_responder.sv
// Bench for lcd_bus_responder: instance "a" uses default timing (never busy), instance "b"
// uses BUSY_CYCLES=4. Both share the bus data/rs/rw and mirror inputs but have separate
// enables. Expected read and mirror values go through a queue as stimulus is issued.
module tb_lcd_bus_responder;
    logic clk = 1'b0;
    logic rst;
    logic [7:0] lcd_data;
    logic lcd_rs, lcd_rw, en_a, en_b;
    logic mir_sel;
    logic [6:0] mir_addr;

    logic [7:0] dout_a, dout_b, mir_a, mir_b;
    logic oe_a, oe_b, busy_a, busy_b, disp_a, disp_b, cur_a, cur_b;
    logic blink_a, blink_b, inc_a, inc_b, drop_a, drop_b;
    logic [6:0] ac_a, ac_b;
    logic [2:0] func_a, func_b;
`ifdef LCD_RESP_TRACE_EN
    logic tv_a, tv_b;
    logic [9:0] tw_a, tw_b;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    lcd_bus_responder dut_a (
        .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(en_a), .lcd_data_out(dout_a), .lcd_data_oe(oe_a), .mir_sel(mir_sel),
        .mir_addr(mir_addr), .mir_data(mir_a), .busy(busy_a), .ac(ac_a),
        .disp_on(disp_a), .cursor_on(cur_a), .blink_on(blink_a), .entry_inc(inc_a),
        .func_bits(func_a),
`ifdef LCD_RESP_TRACE_EN
        .trace_valid(tv_a), .trace_word(tw_a),
`endif
        .drop_flag(drop_a)
    );

    lcd_bus_responder #(.CLEAR_CYCLES(4), .BUSY_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
        .lcd_en(en_b), .lcd_data_out(dout_b), .lcd_data_oe(oe_b), .mir_sel(mir_sel),
        .mir_addr(mir_addr), .mir_data(mir_b), .busy(busy_b), .ac(ac_b),
        .disp_on(disp_b), .cursor_on(cur_b), .blink_on(blink_b), .entry_inc(inc_b),
        .func_bits(func_b),
`ifdef LCD_RESP_TRACE_EN
        .trace_valid(tv_b), .trace_word(tw_b),
`endif
        .drop_flag(drop_b)
    );

    // All stimulus tasks start and end on a falling clock edge.
    task automatic bus_cycle(input bit to_b, input logic rs, input logic rw,
                             input logic [7:0] d, output logic [7:0] rdata,
                             output logic oe_hi, output logic oe_lo);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d;
        if (to_b) en_b = 1'b1; else en_a = 1'b1;
        @(negedge clk);
        rdata = to_b ? dout_b : dout_a;
        oe_hi = to_b ? oe_b : oe_a;
        en_a = 1'b0; en_b = 1'b0;
        @(negedge clk);
        oe_lo = to_b ? oe_b : oe_a;
    endtask

    task automatic wr(input bit to_b, input logic rs, input logic [7:0] d);
        logic [7:0] r;
        logic h, l;
        bus_cycle(to_b, rs, 1'b0, d, r, h, l);
    endtask

    task automatic mir_read(input logic sel, input logic [6:0] addr,
                            output logic [7:0] ga, output logic [7:0] gb);
        mir_sel = sel; mir_addr = addr;
        @(posedge clk);
        #1;
        ga = mir_a; gb = mir_b;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; lcd_data = '0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        en_a = 1'b0; en_b = 1'b0; mir_sel = 1'b0; mir_addr = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({disp_a, cur_a, blink_a, inc_a, func_a, drop_a, busy_a, oe_a} !== 10'b0001000000)
        begin
            errors++;
            $display("FAIL reset_ctrl_a: got %b expected 0001000000",
                     {disp_a, cur_a, blink_a, inc_a, func_a, drop_a, busy_a, oe_a});
        end
        checks++;
        if ({disp_b, cur_b, blink_b, inc_b, func_b, drop_b, busy_b, oe_b} !== 10'b0001000000)
        begin
            errors++;
            $display("FAIL reset_ctrl_b: got %b expected 0001000000",
                     {disp_b, cur_b, blink_b, inc_b, func_b, drop_b, busy_b, oe_b});
        end
        checks++;
        if ({ac_a, ac_b, mir_a, mir_b, dout_a, dout_b} !== '0) begin
            errors++;
            $display("FAIL reset_data: got ac %h/%h mir %h/%h dout %h/%h expected all 0",
                     ac_a, ac_b, mir_a, mir_b, dout_a, dout_b);
        end
        rst = 1'b0;
    endtask

    task automatic test_init();
        wr(0, 0, 8'h01);
        wr(0, 0, 8'h0C);
        wr(0, 0, 8'h38);
        checks++;
        if ({disp_a, cur_a, blink_a} !== 3'b100) begin
            errors++; $display("FAIL init_disp: got %b expected 100", {disp_a, cur_a, blink_a});
        end
        checks++;
        if (func_a !== 3'b110) begin
            errors++; $display("FAIL init_func: got %b expected 110", func_a);
        end
        checks++;
        if (ac_a !== 7'h00 || drop_a !== 1'b0) begin
            errors++; $display("FAIL init_ac_drop: got ac %h drop %b expected 00 0", ac_a, drop_a);
        end
    endtask

    task automatic test_cgram_load();
        logic [7:0] ga, gb, exp, rd;
        logic hi, lo;
        wr(0, 0, 8'h40);
        for (int i = 0; i < 8; i++) wr(0, 1, 8'h03);
        wr(0, 0, 8'h48);
        for (int i = 0; i < 8; i++) wr(0, 1, 8'h0F);
        checks++;
        if (ac_a !== 7'h10) begin
            errors++; $display("FAIL cg_ac: got %h expected 10", ac_a);
        end
        for (int i = 0; i < 16; i++) exp_q.push_back(i < 8 ? 8'h03 : 8'h0F);
        for (int i = 0; i < 16; i++) begin
            mir_read(1'b1, 7'(i), ga, gb);
            exp = exp_q.pop_front();
            checks++;
            if (ga !== exp) begin
                errors++; $display("FAIL cg_mir[%0d]: got %h expected %h", i, ga, exp);
            end
        end
        // Bus data read from CGRAM row 8.
        wr(0, 0, 8'h48);
        exp_q.push_back(8'h0F);
        bus_cycle(0, 1'b1, 1'b1, 8'h00, rd, hi, lo);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || hi !== 1'b1 || lo !== 1'b0) begin
            errors++;
            $display("FAIL cg_read: got %h oe %b/%b expected %h oe 1/0", rd, hi, lo, exp);
        end
        checks++;
        if (ac_a !== 7'h09) begin
            errors++; $display("FAIL cg_read_ac: got %h expected 09", ac_a);
        end
    endtask

    task automatic test_char6_wrap();
        logic [7:0] c6 [8];
        logic [7:0] ga, gb, exp;
        c6 = '{8'h00, 8'h02, 8'h02, 8'h03, 8'h0F, 8'h1E, 8'h0A, 8'h0A};
        wr(0, 0, 8'h70);
        for (int i = 0; i < 8; i++) begin
            wr(0, 1, c6[i]);
            exp_q.push_back(c6[i]);
        end
        for (int i = 0; i < 8; i++) begin
            mir_read(1'b1, 7'(48 + i), ga, gb);
            exp = exp_q.pop_front();
            checks++;
            if (ga !== exp) begin
                errors++; $display("FAIL c6_mir[%0d]: got %h expected %h", 48 + i, ga, exp);
            end
        end
        wr(0, 0, 8'h7F);
        wr(0, 1, 8'hAA);
        checks++;
        if (ac_a !== 7'h00) begin
            errors++; $display("FAIL cg_wrap_up: got %h expected 00", ac_a);
        end
        wr(0, 0, 8'h04);
        wr(0, 0, 8'h40);
        wr(0, 1, 8'h55);
        checks++;
        if (ac_a !== 7'h3F) begin
            errors++; $display("FAIL cg_wrap_down: got %h expected 3f", ac_a);
        end
        wr(0, 0, 8'h06);
    endtask

    task automatic test_ddram();
        logic [7:0] ga, gb, exp, rd;
        logic hi, lo;
        wr(0, 0, 8'hFF);
        wr(0, 1, 8'h06);
        wr(0, 1, 8'h05);
        checks++;
        if (ac_a !== 7'h01) begin
            errors++; $display("FAIL dd_ac: got %h expected 01", ac_a);
        end
        exp_q.push_back(8'h06); exp_q.push_back(8'h05); exp_q.push_back(8'h20);
        for (int i = 0; i < 3; i++) begin
            mir_read(1'b0, i == 0 ? 7'h7F : 7'(i - 1), ga, gb);
            exp = exp_q.pop_front();
            checks++;
            if (ga !== exp) begin
                errors++; $display("FAIL dd_mir[%0d]: got %h expected %h", i, ga, exp);
            end
        end
        wr(0, 0, 8'hFF);
        exp_q.push_back(8'h06);
        bus_cycle(0, 1'b1, 1'b1, 8'h00, rd, hi, lo);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || hi !== 1'b1 || lo !== 1'b0 || ac_a !== 7'h00) begin
            errors++;
            $display("FAIL dd_read: got %h oe %b/%b ac %h expected %h oe 1/0 ac 00",
                     rd, hi, lo, ac_a, exp);
        end
        wr(0, 0, 8'h85);
        exp_q.push_back(8'h05);
        bus_cycle(0, 1'b0, 1'b1, 8'h00, rd, hi, lo);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || ac_a !== 7'h05) begin
            errors++; $display("FAIL status_read: got %h ac %h expected %h ac 05", rd, ac_a, exp);
        end
        wr(0, 0, 8'h80);
        wr(0, 0, 8'h14);
        wr(0, 0, 8'h1C);
        checks++;
        if (ac_a !== 7'h01) begin
            errors++; $display("FAIL shift_right: got %h expected 01", ac_a);
        end
        wr(0, 0, 8'h10);
        wr(0, 0, 8'h10);
        checks++;
        if (ac_a !== 7'h7F) begin
            errors++; $display("FAIL shift_left_wrap: got %h expected 7f", ac_a);
        end
        wr(0, 0, 8'h04);
        wr(0, 0, 8'h01);
        checks++;
        if (ac_a !== 7'h00 || inc_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: got ac %h inc %b busy %b expected 00 1 0",
                     ac_a, inc_a, busy_a);
        end
        exp_q.push_back(8'h20); exp_q.push_back(8'h20);
        for (int i = 0; i < 2; i++) begin
            mir_read(1'b0, i == 0 ? 7'h7F : 7'h00, ga, gb);
            exp = exp_q.pop_front();
            checks++;
            if (ga !== exp) begin
                errors++; $display("FAIL clear_mir[%0d]: got %h expected %h", i, ga, exp);
            end
        end
    endtask

    task automatic test_busy_drop();
        logic [7:0] ga, gb, exp, rd;
        logic hi, lo;
        wr(1, 0, 8'h0C);
        checks++;
        if (busy_b !== 1'b1 || disp_b !== 1'b1) begin
            errors++; $display("FAIL busy_set: got busy %b disp %b expected 1 1", busy_b, disp_b);
        end
        wr(1, 1, 8'h41);
        checks++;
        if (drop_b !== 1'b1 || ac_b !== 7'h00) begin
            errors++; $display("FAIL drop: got drop %b ac %h expected 1 00", drop_b, ac_b);
        end
        exp_q.push_back(8'h80);
        bus_cycle(1, 1'b0, 1'b1, 8'h00, rd, hi, lo);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp || hi !== 1'b1) begin
            errors++; $display("FAIL busy_read: got %h oe %b expected %h oe 1", rd, hi, exp);
        end
        for (int i = 0; i < 10 && busy_b; i++) @(negedge clk);
        checks++;
        if (busy_b !== 1'b0) begin
            errors++; $display("FAIL busy_timeout: got busy %b expected 0", busy_b);
        end
        exp_q.push_back(8'h00);
        bus_cycle(1, 1'b0, 1'b1, 8'h00, rd, hi, lo);
        exp = exp_q.pop_front();
        checks++;
        if (rd !== exp) begin
            errors++; $display("FAIL idle_read: got %h expected %h", rd, exp);
        end
        exp_q.push_back(8'h20);
        mir_read(1'b0, 7'h00, ga, gb);
        exp = exp_q.pop_front();
        checks++;
        if (gb !== exp) begin
            errors++; $display("FAIL drop_mem: got %h expected %h", gb, exp);
        end
    endtask

    task automatic test_reset_mid_burst();
        wr(0, 0, 8'h40);
        wr(0, 1, 8'h11);
        wr(0, 1, 8'h12);
        lcd_rs = 1'b1; lcd_rw = 1'b0; lcd_data = 8'h13; en_a = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({disp_a, cur_a, blink_a, inc_a, func_a, ac_a, mir_a} !== {4'b0001, 3'b000, 7'h00, 8'h00})
        begin
            errors++;
            $display("FAIL mid_reset: got ctrl %b func %b ac %h mir %h expected 0001 000 00 00",
                     {disp_a, cur_a, blink_a, inc_a}, func_a, ac_a, mir_a);
        end
        checks++;
        if (drop_b !== 1'b0) begin
            errors++; $display("FAIL mid_reset_drop: got %b expected 0", drop_b);
        end
        @(negedge clk);
        en_a = 1'b0;
        rst = 1'b0;
        wr(0, 0, 8'h0C);
        checks++;
        if ({disp_a, cur_a, blink_a, func_a, ac_a} !== {3'b100, 3'b000, 7'h00}) begin
            errors++;
            $display("FAIL post_reset_cmd: got disp %b func %b ac %h expected 100 000 00",
                     {disp_a, cur_a, blink_a}, func_a, ac_a);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_cgram_load();
        test_char6_wrap();
        test_ddram();
        test_busy_drop();
        test_reset_mid_burst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
